// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for debug_trace_buffer.
//   trace_state_e - capture FSM state encoding (IDLE, ARMED, CAPTURE, DONE)
//   MODE_ONESHOT  - stop capturing once the buffer is full
//   MODE_RING     - keep capturing, overwriting the oldest entry
package trace_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } trace_state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RING    = 1'b1;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x DATA_WIDTH storage for the trace buffer.
//   clk_i   - write clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address (asynchronous read)
//   rdata_o - read data, combinational from raddr_i
// Contents are intentionally not reset.
module trace_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: triggered capture of a debug word into a small buffer,
// then show-ahead readout oldest first.
//   clk, reset       - clock, asynchronous active-high reset
//   start, mode      - arm request (IDLE only); mode 0 one-shot, 1 ring
//   trigger          - opens the capture window (ARMED only)
//   stop             - closes the window early (CAPTURE only)
//   debug_in         - word to record, qualified by sample_valid
//   rd_ready         - consumer accepts rd_data (DONE only)
//   rd_valid/rd_data - unread entry available / oldest unread entry
//   rd_last          - rd_data is the final entry
//   busy, done       - ARMED or CAPTURE / one-cycle pulse on entering DONE
//   overflow, count  - ring overwrote data / entries held
module debug_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MAX_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       trigger,
    input  logic                       stop,
    input  logic [DATA_WIDTH-1:0]      debug_in,
    input  logic                       sample_valid,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_last,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [31:0]     WinLen  = 32'(MAX_CYCLES);

    trace_state_e    state_q, state_d;
    logic            mode_q, mode_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     cyc_q, cyc_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;
    logic            ram_we;
    logic            in_window;
    logic            stop_hit;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cyc_d      = cyc_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        in_window  = 1'b0;
        stop_hit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d     = mode;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    cyc_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = StArmed;
                end
            end
            // The trigger cycle is itself window cycle 1.
            StArmed: in_window = trigger;
            StCapture: begin
                in_window = 1'b1;
                stop_hit  = stop;
            end
            StDone: begin
                if (count_q == '0) begin
                    state_d = StIdle;
                end else if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                    count_d  = count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_window) begin
            cyc_d = cyc_q + 32'd1;
            if (sample_valid) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                if (count_q == CntFull) begin
                    // Only reachable in ring mode: the newest word lands on the
                    // oldest, so the read pointer moves past it.
                    rd_ptr_d   = rd_ptr_q + PtrW'(1);
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end
            if (cyc_d >= WinLen || stop_hit ||
                (mode_q == MODE_ONESHOT && count_d == CntFull)) begin
                state_d = StDone;
                done_d  = 1'b1;
            end else begin
                state_d = StCapture;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_q     <= MODE_ONESHOT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    trace_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .waddr_i(wr_ptr_q),
        .wdata_i(debug_in),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_data)
    );

    assign rd_valid = (state_q == StDone) && (count_q != '0);
    assign rd_last  = rd_valid && (count_q == CntW'(1));
    assign busy     = (state_q == StArmed) || (state_q == StCapture);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule

// File: doc/debug_trace_buffer.md
DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, giving the width of the sampled debug word.
REQ-002 The block SHALL take parameter DEPTH, default 16, giving buffer entries (power of two, >=2).
REQ-003 The block SHALL take parameter MAX_CYCLES, default 10, giving the capture-window length in clock cycles (>=1, <2^32).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, arm request, honoured only in IDLE.
REQ-007 The block SHALL have port mode, input, 1, sampled with start: 0 = one-shot, 1 = ring.
REQ-008 The block SHALL have port trigger, input, 1, opens the capture window, honoured only in ARMED.
REQ-009 The block SHALL have port stop, input, 1, early end of capture, honoured only in CAPTURE.
REQ-010 The block SHALL have port debug_in, input, DATA_WIDTH, word to record.
REQ-011 The block SHALL have port sample_valid, input, 1, qualifies debug_in for writing.
REQ-012 The block SHALL have port rd_ready, input, 1, consumer accepts rd_data.
REQ-013 The block SHALL have port rd_valid, output, 1, rd_data holds an unread entry.
REQ-014 The block SHALL have port rd_data, output, DATA_WIDTH, oldest unread entry (show-ahead).
REQ-015 The block SHALL have port rd_last, output, 1, rd_data is the final entry.
REQ-016 The block SHALL have ports busy (1, high in ARMED/CAPTURE), done (1, one-cycle pulse on entering DONE), overflow (1, ring overwrote data), count ($clog2(DEPTH+1), entries held).

Function
REQ-017 The block SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-018 IDLE + start SHALL latch mode, clear pointers, count, overflow, and go to ARMED next cycle.
REQ-019 ARMED + trigger SHALL go to CAPTURE; the trigger cycle itself SHALL count as window cycle 1 and SHALL write debug_in if sample_valid.
REQ-020 In ARMED/CAPTURE each window cycle with sample_valid high SHALL write debug_in at the write pointer; cycles without sample_valid SHALL still consume the window.
REQ-021 The window SHALL close after exactly MAX_CYCLES cycles, or on the cycle stop is high, whichever is first; a write in the closing cycle SHALL be kept; next state DONE.
REQ-022 One-shot: when count reaches DEPTH the window SHALL close immediately, further samples dropped.
REQ-023 Ring: write pointer SHALL wrap DEPTH-1 -> 0, overwrite the oldest entry, count saturates at DEPTH, overflow set at the first overwrite and held until next start.
REQ-024 DONE: rd_valid SHALL be high while count > 0; rd_data SHALL present entries oldest first with zero-cycle latency from the read pointer.
REQ-025 A transfer SHALL occur on rd_valid && rd_ready; it SHALL advance the read pointer (wrapping) and decrement count.
REQ-026 rd_last SHALL be high exactly when rd_valid and count == 1.
REQ-027 After the last transfer, or on entering DONE with count == 0, the block SHALL return to IDLE next cycle.
REQ-028 start outside IDLE, trigger outside ARMED, stop outside CAPTURE, and rd_ready outside DONE SHALL be ignored.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE, pointers/count/cycle counter 0, and rd_valid, rd_last, busy, done, overflow 0, including mid-capture or mid-readout.
REQ-030 Buffer RAM contents SHALL NOT be reset; rd_data is don't-care while rd_valid is low.

Structure
REQ-031 State encoding and mode constants (MODE_ONESHOT, MODE_RING) SHALL live in shared package trace_pkg.
REQ-032 Storage SHALL be sub-module trace_ram: DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port.

Verification
REQ-033 One-shot, MAX_CYCLES=10, DEPTH=16, sample_valid always 1, debug_in = cycle index 0..9 -> 10 entries read 0..9, rd_last on 9, overflow 0.
REQ-034 Ring, MAX_CYCLES=20, DEPTH=16, data 0..19 -> count 16, read 4..19, overflow 1.
REQ-035 One-shot, MAX_CYCLES=40, DEPTH=16 -> window closes after 16 writes, done pulses next cycle, read 0..15.
REQ-036 stop on window cycle 3, sample_valid 1 -> 3 entries; alternate sample_valid 1/0 for 10 cycles -> 5 entries.
REQ-037 rd_ready toggled 1/0 during readout -> no entry lost or duplicated, order preserved.
REQ-038 reset asserted at window cycle 5 -> outputs 0 same cycle; subsequent start/trigger run captures cleanly from count 0.
